// File: rtl/key_entry.sv
// key_entry: push-button front-end for the lock controller.
// Synchronises and debounces six raw buttons, turns each clean press into a
// one-cycle event, and assembles an 8-bit code one bit per press. A complete
// code is submitted with a one-cycle confirm pulse and then held on pw_8.
module key_entry #(
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned IDLE_CYCLES = 500000000
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       btn_zero,
   input  logic       btn_one,
   input  logic       btn_del,
   input  logic       btn_ok,
   input  logic       btn_clr,
   input  logic       btn_lock,
   output logic [7:0] pw_8,
   output logic       confirm,
   output logic       lock,
   output logic [3:0] digit_cnt,
   output logic       entry_err
);

   localparam int NUM_BTN = 6;
   localparam int B_ZERO  = 0;
   localparam int B_ONE   = 1;
   localparam int B_DEL   = 2;
   localparam int B_OK    = 3;
   localparam int B_CLR   = 4;
   localparam int B_LOCK  = 5;

   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, SENT} state_t;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] sync_q1;
   logic [NUM_BTN-1:0] sync_q2;
   logic [NUM_BTN-1:0] stable;
   logic [NUM_BTN-1:0] press;
   logic [DEB_W-1:0]   deb_cnt [NUM_BTN];

   state_t            state, state_nxt;
   logic [7:0]        shift_reg, shift_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;
   logic              confirm_nxt, lock_nxt, err_nxt;

   assign btn_raw = {btn_lock, btn_clr, btn_ok, btn_del, btn_one, btn_zero};

   // Two-flop synchroniser bringing the raw buttons into the Clk domain.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the value from
         // before the edge; blocking here would collapse the two stages into one.
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: a level change is accepted only after DEB_CYCLES consecutive
   // disagreeing samples; a 0->1 acceptance emits a one-cycle press event.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         press  <= '0;
         // NOTE: the counter array is a handful of flops, not a RAM, so it is
         // reset like any other register.
         for (int i = 0; i < NUM_BTN; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            press[i] <= 1'b0;
            if (sync_q2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync_q2[i];
               deb_cnt[i] <= '0;
               press[i]   <= sync_q2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Entry FSM: applies press events by priority clr > ok > del > digit,
   // with lock handled alongside, plus the idle-timeout discard.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      shift_nxt   = shift_reg;
      cnt_nxt     = cnt;
      idle_nxt    = idle_cnt;
      confirm_nxt = 1'b0;
      lock_nxt    = 1'b0;
      err_nxt     = 1'b0;

      if (press[B_CLR]) begin
         state_nxt = EMPTY;
         shift_nxt = '0;
         cnt_nxt   = '0;
      end else if (press[B_OK]) begin
         if (state == FULL) begin
            confirm_nxt = 1'b1;
            state_nxt   = SENT;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (press[B_DEL]) begin
         case (state)
            PARTIAL, FULL: begin
               shift_nxt = {1'b0, shift_reg[7:1]};
               cnt_nxt   = cnt - 4'd1;
               state_nxt = (cnt == 4'd1) ? EMPTY : PARTIAL;
            end
            SENT: begin
               state_nxt = EMPTY;
               shift_nxt = '0;
               cnt_nxt   = '0;
            end
            default: err_nxt = 1'b1;
         endcase
      end else if (press[B_ZERO] || press[B_ONE]) begin
         if (press[B_ZERO] && press[B_ONE]) begin
            err_nxt = 1'b1;
         end else begin
            case (state)
               EMPTY, PARTIAL: begin
                  shift_nxt = {shift_reg[6:0], press[B_ONE]};
                  cnt_nxt   = cnt + 4'd1;
                  state_nxt = (cnt == 4'd7) ? FULL : PARTIAL;
               end
               SENT: begin
                  shift_nxt = {7'b0, press[B_ONE]};
                  cnt_nxt   = 4'd1;
                  state_nxt = PARTIAL;
               end
               default: err_nxt = 1'b1;
            endcase
         end
      end

      // Lock also wipes the entry, overriding whatever the chain above decided.
      if (press[B_LOCK]) begin
         lock_nxt  = 1'b1;
         state_nxt = EMPTY;
         shift_nxt = '0;
         cnt_nxt   = '0;
      end

      // Idle timer: restarted by any press, counts only while an entry is open.
      if (|press) begin
         idle_nxt = '0;
      end else if (state == PARTIAL || state == FULL) begin
         if (idle_cnt == IDLE_LAST) begin
            idle_nxt  = '0;
            state_nxt = EMPTY;
            shift_nxt = '0;
            cnt_nxt   = '0;
         end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
         end
      end
   end

   // Entry state and registered outputs.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         shift_reg <= '0;
         cnt       <= '0;
         idle_cnt  <= '0;
         confirm   <= 1'b0;
         lock      <= 1'b0;
         entry_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         cnt       <= cnt_nxt;
         idle_cnt  <= idle_nxt;
         confirm   <= confirm_nxt;
         lock      <= lock_nxt;
         entry_err <= err_nxt;
      end
   end

   assign pw_8      = shift_reg;
   assign digit_cnt = cnt;

endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: directed and random button stimulus against a queue-based
// reference model of the key-entry behaviour, compared every cycle.
module tb_key_entry;

   localparam int DEB  = 4;
   localparam int IDLE = 100;

   logic       Clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_zero = 1'b0, btn_one = 1'b0, btn_del = 1'b0;
   logic       btn_ok = 1'b0, btn_clr = 1'b0, btn_lock = 1'b0;
   logic [7:0] pw_8;
   logic       confirm, lock, entry_err;
   logic [3:0] digit_cnt;

   key_entry #(.DEB_CYCLES(DEB), .IDLE_CYCLES(IDLE)) dut (
      .Clk       (Clk),
      .reset     (reset),
      .btn_zero  (btn_zero),
      .btn_one   (btn_one),
      .btn_del   (btn_del),
      .btn_ok    (btn_ok),
      .btn_clr   (btn_clr),
      .btn_lock  (btn_lock),
      .pw_8      (pw_8),
      .confirm   (confirm),
      .lock      (lock),
      .digit_cnt (digit_cnt),
      .entry_err (entry_err)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int conf_cnt = 0, conf_cyc = 0, lock_cnt = 0, lock_cyc = 0, err_cnt = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: buttons indexed 0 zero,1 one,2 del,3 ok,4 clr,5 lock.
   logic [5:0] s1 = '0, s2 = '0, stb = '0, evt = '0;
   int         run [6];
   bit         q [$];
   bit         sent = 1'b0;
   int         idle = 0;
   logic [7:0] m_pw = '0;
   logic [3:0] m_cnt = '0;
   bit         m_conf = 1'b0, m_lock = 1'b0, m_err = 1'b0;

   task automatic model_reset();
      s1 = '0; s2 = '0; stb = '0; evt = '0;
      for (int i = 0; i < 6; i++) run[i] = 0;
      q.delete();
      sent = 1'b0; idle = 0;
      m_pw = '0; m_cnt = '0; m_conf = 1'b0; m_lock = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      logic [5:0] e;
      logic [5:0] raw;
      raw = {btn_lock, btn_clr, btn_ok, btn_del, btn_one, btn_zero};
      e = evt;
      m_conf = 1'b0; m_lock = 1'b0; m_err = 1'b0;
      if (e[4]) begin
         q.delete(); sent = 1'b0;
      end else if (e[3]) begin
         if (!sent && q.size() == 8) begin m_conf = 1'b1; sent = 1'b1; end
         else m_err = 1'b1;
      end else if (e[2]) begin
         if (sent) begin q.delete(); sent = 1'b0; end
         else if (q.size() == 0) m_err = 1'b1;
         else void'(q.pop_back());
      end else if (e[0] || e[1]) begin
         if (e[0] && e[1]) m_err = 1'b1;
         else if (sent) begin q.delete(); q.push_back(e[1]); sent = 1'b0; end
         else if (q.size() == 8) m_err = 1'b1;
         else q.push_back(e[1]);
      end
      if (e[5]) begin m_lock = 1'b1; q.delete(); sent = 1'b0; end
      if (e != 0) idle = 0;
      else if (!sent && q.size() > 0) begin
         if (idle == IDLE - 1) begin q.delete(); idle = 0; end
         else idle++;
      end
      // A level is accepted after DEB consecutive samples that disagree with it.
      for (int i = 0; i < 6; i++) begin
         evt[i] = 1'b0;
         if (s2[i] != stb[i]) begin
            run[i]++;
            if (run[i] == DEB) begin
               stb[i] = s2[i]; run[i] = 0; evt[i] = s2[i];
            end
         end else begin
            run[i] = 0;
         end
      end
      s2 = s1;
      s1 = raw;
      m_pw = '0;
      foreach (q[i]) m_pw = {m_pw[6:0], q[i]};
      m_cnt = 4'(q.size());
   endtask

   always @(posedge Clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         check("pw_8", 32'(pw_8), 32'(m_pw));
         check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
         check("confirm", 32'(confirm), 32'(m_conf));
         check("lock", 32'(lock), 32'(m_lock));
         check("entry_err", 32'(entry_err), 32'(m_err));
         if (confirm) begin conf_cnt++; conf_cyc = cyc; end
         if (lock) begin lock_cnt++; lock_cyc = cyc; end
         if (entry_err) err_cnt++;
      end
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0: btn_zero = v;
         1: btn_one  = v;
         2: btn_del  = v;
         3: btn_ok   = v;
         4: btn_clr  = v;
         default: btn_lock = v;
      endcase
   endtask

   task automatic press(input int idx, input int hold, input int gap);
      set_btn(idx, 1'b1);
      tick(hold);
      set_btn(idx, 1'b0);
      tick(gap);
   endtask

   task automatic enter_bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) press(v[i] ? 1 : 0, 10, 10);
   endtask

   initial begin
      int c;
      int r;
      int idx;
      model_reset();
      tick(3);
      reset = 1'b1;
      tick(2);
      check("reset_pw", 32'(pw_8), 32'h0);
      check("reset_cnt", 32'(digit_cnt), 32'h0);

      // Full code entry and submit.
      enter_bits(8'hB2, 8);
      check("full_pw", 32'(pw_8), 32'hB2);
      check("full_cnt", 32'(digit_cnt), 32'd8);
      conf_cnt = 0;
      c = cyc;
      press(3, 10, 10);
      check("ok_latency", 32'(conf_cyc - c), 32'd7);
      check("ok_confirms", 32'(conf_cnt), 32'd1);
      tick(200);
      check("sent_hold_pw", 32'(pw_8), 32'hB2);

      // Glitching button gives a single event.
      press(4, 10, 10);
      btn_one = 1'b1; tick(2);
      btn_one = 1'b0; tick(2);
      btn_one = 1'b1; tick(2);
      btn_one = 1'b0; tick(2);
      btn_one = 1'b1; tick(10);
      btn_one = 1'b0; tick(10);
      check("glitch_cnt", 32'(digit_cnt), 32'd1);
      check("glitch_pw", 32'(pw_8), 32'h1);

      // Early ok, deletes, delete on empty.
      press(4, 10, 10);
      enter_bits(8'h05, 3);
      err_cnt = 0; conf_cnt = 0;
      press(3, 10, 10);
      check("early_ok_err", 32'(err_cnt), 32'd1);
      check("early_ok_conf", 32'(conf_cnt), 32'd0);
      press(2, 10, 10);
      check("del_pw", 32'(pw_8), 32'h02);
      check("del_cnt", 32'(digit_cnt), 32'd2);
      err_cnt = 0;
      press(2, 10, 10);
      press(2, 10, 10);
      check("del2_err", 32'(err_cnt), 32'd0);
      press(2, 10, 10);
      check("del_empty_err", 32'(err_cnt), 32'd1);
      check("del_empty_cnt", 32'(digit_cnt), 32'd0);

      // Overfill, then a new entry started from SENT.
      enter_bits(8'hA5, 8);
      err_cnt = 0;
      press(1, 10, 10);
      check("overfill_err", 32'(err_cnt), 32'd1);
      check("overfill_pw", 32'(pw_8), 32'hA5);
      press(3, 10, 10);
      press(0, 10, 10);
      check("restart_pw", 32'(pw_8), 32'h00);
      check("restart_cnt", 32'(digit_cnt), 32'd1);

      // Idle timeout on a partial entry, then SENT held through idle.
      press(4, 10, 10);
      enter_bits(8'h16, 5);
      err_cnt = 0;
      tick(120);
      check("idle_cnt", 32'(digit_cnt), 32'd0);
      check("idle_pw", 32'(pw_8), 32'h0);
      check("idle_err", 32'(err_cnt), 32'd0);
      enter_bits(8'h3C, 8);
      press(3, 10, 10);
      tick(300);
      check("sent_idle_pw", 32'(pw_8), 32'h3C);
      check("sent_idle_cnt", 32'(digit_cnt), 32'd8);

      // ok and lock together while FULL.
      press(4, 10, 10);
      enter_bits(8'hC3, 8);
      conf_cnt = 0; lock_cnt = 0;
      btn_ok = 1'b1; btn_lock = 1'b1;
      tick(10);
      btn_ok = 1'b0; btn_lock = 1'b0;
      tick(10);
      check("ok_lock_conf", 32'(conf_cnt), 32'd1);
      check("ok_lock_lock", 32'(lock_cnt), 32'd1);
      check("ok_lock_same", 32'(conf_cyc), 32'(lock_cyc));
      check("ok_lock_cnt", 32'(digit_cnt), 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 19);
         if (r == 19) begin
            tick($urandom_range(80, 130));
         end else if (r == 18) begin
            btn_zero = 1'b1; btn_one = 1'b1;
            tick($urandom_range(1, 12));
            btn_zero = 1'b0; btn_one = 1'b0;
            tick($urandom_range(1, 12));
         end else begin
            if (r < 12) idx = $urandom_range(0, 1);
            else if (r < 14) idx = 2;
            else if (r < 16) idx = 3;
            else if (r == 16) idx = 4;
            else idx = 5;
            press(idx, $urandom_range(1, 12), $urandom_range(1, 12));
         end
      end

      // Asynchronous reset in the middle of an entry.
      press(4, 10, 10);
      enter_bits(8'h05, 3);
      btn_one = 1'b1;
      tick(6);
      #2 reset = 1'b0;
      #1;
      check("async_pw", 32'(pw_8), 32'h0);
      check("async_cnt", 32'(digit_cnt), 32'h0);
      check("async_conf", 32'(confirm), 32'h0);
      check("async_err", 32'(entry_err), 32'h0);
      btn_one = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Input front-end that drives the lock controller's code and command inputs (pw_8, confirm, lock) from raw push-buttons.
- Synchronises and debounces six buttons and assembles an 8-bit code one bit per press, with delete and clear.
- Emits a one-cycle confirm pulse only when a complete code is present, and holds that code stable after the pulse so the checker can sample it.
- Sits between the board buttons and the main controller, in the Clk domain.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz)
IDLE_CYCLES, 500000000, cycles with no press event before a partial or full entry is discarded (5 s)

Ports:
Clk  input  1  system clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
btn_zero  input  1  raw button; appends bit 0
btn_one  input  1  raw button; appends bit 1
btn_del  input  1  raw button; removes the last bit
btn_ok  input  1  raw button; submits the code
btn_clr  input  1  raw button; discards the entry
btn_lock  input  1  raw button; lock request
pw_8  output  8  assembled code, MSB = first bit entered
confirm  output  1  one-cycle submit pulse to the checker
lock  output  1  one-cycle lock pulse
digit_cnt  output  4  number of bits entered (0..8), for the display
entry_err  output  1  one-cycle pulse on an invalid key action

Behaviour:
- Reset (reset=0, asynchronous): synchronisers, debounce counters and stable levels = 0; shift_reg = 0; cnt = 0; idle counter = 0; state = EMPTY; all outputs = 0.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter clears whenever the synchronised level equals the stable level; otherwise it increments, and at DEB_CYCLES-1 the stable level takes the new value and the counter clears.
  - Press event = one-cycle pulse on a stable 0->1 transition. Release generates nothing.
  - Latency from a clean raw edge to the event: 2 + DEB_CYCLES cycles.
  - A held button generates exactly one event.
- States: EMPTY (cnt=0), PARTIAL (1..7), FULL (cnt=8), SENT (code submitted and held).
- Event priority in one cycle: clr > ok > del > digit. lock is processed independently, in parallel. zero and one in the same cycle: both ignored and entry_err pulses.
- Digit event:
  - EMPTY/PARTIAL: shift_reg <= {shift_reg[6:0], bit}; cnt+1; cnt reaching 8 moves to FULL.
  - FULL: ignored; entry_err pulses.
  - SENT: starts a new entry: shift_reg <= {7'b0, bit}; cnt = 1; state PARTIAL.
- Del event:
  - PARTIAL/FULL: shift_reg <= {1'b0, shift_reg[7:1]}; cnt-1.
  - EMPTY: entry_err pulses.
  - SENT: behaves as clr.
- Ok event:
  - FULL: confirm = 1 for exactly the next cycle; state SENT; pw_8 unchanged.
  - Any other state: entry_err pulses; no confirm.
- Clr event: shift_reg = 0, cnt = 0, state EMPTY, from any state.
- Lock event: lock = 1 for exactly the next cycle; the entry is also cleared to EMPTY. If lock coincides with ok in FULL, both confirm and lock pulse and the final state is EMPTY.
- Idle timeout:
  - Counter clears on any press event and counts only in PARTIAL/FULL.
  - On reaching IDLE_CYCLES-1 the entry clears to EMPTY with no error pulse.
  - Frozen in EMPTY and SENT; SENT holds pw_8 indefinitely so the checker's countdown auto-submit sees a valid code.
- Output timing:
  - pw_8 = shift_reg and digit_cnt = cnt, both registered and updated the cycle after the event.
  - confirm, lock and entry_err are registered, never wider than one cycle.
- Reset asserted mid-entry or during a confirm pulse clears everything immediately; no pulse completes.

Test Plan:
- DEB_CYCLES=4, IDLE_CYCLES=100 for all scenarios.
- Press one,0,1,1,0,0,1,0 (each held 10 cycles, 10 gap) then ok -> pw_8=8'hB2, digit_cnt=8; exactly one confirm cycle, 7 cycles after the ok raw edge; pw_8 still 8'hB2 200 cycles later.
- btn_one glitching 1-0-1 with 2-cycle periods, then held -> single press event only after 4 stable cycles; digit_cnt=1.
- Enter 3 bits (1,0,1) then ok -> entry_err one cycle, no confirm; del -> pw_8=8'h02, digit_cnt=2; del,del,del -> third del gives entry_err, digit_cnt=0.
- Enter 8 bits, press one again -> entry_err, pw_8 unchanged; from SENT press zero -> pw_8=8'h00, digit_cnt=1.
- Enter 5 bits, idle 100+ cycles -> digit_cnt=0, pw_8=0, no entry_err; in SENT, idle 300 cycles -> pw_8 held.
- FULL, ok and lock raw edges in the same cycle -> confirm and lock both pulse in the same cycle, then digit_cnt=0; reset pulled low mid-entry -> all outputs 0 asynchronously.
